// File: rtl/card_pkg.sv
// Shared types and constants for the playing-card seven-segment display.
package card_pkg;

  typedef enum logic [1:0] {
    DIAMOND = 2'b00,
    HEART   = 2'b01,
    CLUB    = 2'b10,
    SPADE   = 2'b11
  } suit_t;

  // Rank 0 marks an empty card slot; 1..13 are A..K, 14 and 15 show a dash.
  typedef logic [3:0] rank_t;

  typedef struct packed {
    rank_t rank;
    suit_t suit;
  } card_t;

  localparam int NUM_DIGITS      = 8;
  localparam int NUM_SHOWN_CARDS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

endpackage

// File: rtl/bto7s_rank.sv
// Rank glyph decoder: 4-bit card rank to active-high gfedcba segments.
module bto7s_rank
  import card_pkg::*;
(
  input  rank_t      rank,
  output logic [6:0] seg
);

  // Ranks above king have no glyph of their own and fall back to a dash.
  always_comb begin
    seg = SEG_DASH;
    case (rank)
      4'd1:    seg = 7'b1110111;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      4'd10:   seg = 7'b1111000;
      4'd11:   seg = 7'b0011110;
      4'd12:   seg = 7'b1100111;
      4'd13:   seg = 7'b1110110;
      4'd0:    seg = 7'b0000000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bto7s_suit.sv
// Suit glyph decoder: 2-bit suit code to active-high gfedcba segments.
module bto7s_suit (
  input  logic [1:0] suit,
  output logic [6:0] seg
);

  // Fixed glyphs: d, h, c, S.
  always_comb begin
    seg = 7'b0000000;
    case (suit)
      2'b00:   seg = 7'b1011110;
      2'b01:   seg = 7'b1110100;
      2'b10:   seg = 7'b1011000;
      default: seg = 7'b1101101;
    endcase
  end

endmodule

// File: rtl/card_seg_scanner.sv
// Time-multiplexed 8-digit display of up to four cards (rank digit + suit digit),
// with per-card blinking and frame-aligned double buffering of card updates.
module card_seg_scanner
  import card_pkg::*;
#(
  parameter int COUNT_PERIOD = 100000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [23:0] cards_in,
  input  logic [3:0]  blink_in,
  input  logic        cards_valid_in,
  output logic [6:0]  cat_out,
  output logic [7:0]  an_out,
  output logic        frame_out
);

  localparam int CNT_W = $clog2(COUNT_PERIOD);
  localparam int BLK_W = $clog2(BLINK_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       digit_idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  card_t [NUM_SHOWN_CARDS-1:0] pend_cards;
  card_t [NUM_SHOWN_CARDS-1:0] act_cards;
  logic  [NUM_SHOWN_CARDS-1:0] pend_blink;
  logic  [NUM_SHOWN_CARDS-1:0] act_blink;
  logic                        pend_flag;

  logic       cnt_tc;
  logic       wrap;
  card_t      cur_card;
  logic       cur_blank;
  logic [6:0] rank_seg;
  logic [6:0] suit_seg;
  logic [6:0] glyph;

  assign cnt_tc = (cnt == CNT_W'(COUNT_PERIOD - 1));
  assign wrap   = cnt_tc && (digit_idx == 3'd7);

  // Each pair of digits belongs to one card; card 0 sits on the two rightmost digits.
  assign cur_card  = act_cards[digit_idx[2:1]];
  assign cur_blank = (cur_card.rank == 4'd0) ||
                     (blink_phase && act_blink[digit_idx[2:1]]);
  assign glyph     = digit_idx[0] ? rank_seg : suit_seg;

  bto7s_rank u_rank (
    .rank (cur_card.rank),
    .seg  (rank_seg)
  );

  bto7s_suit u_suit (
    .suit (cur_card.suit),
    .seg  (suit_seg)
  );

  // Refresh counter: hold each digit for COUNT_PERIOD cycles, then step to the next.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt       <= '0;
      digit_idx <= 3'd0;
    end else if (cnt_tc) begin
      cnt       <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Free-running blink timer; the phase flips once per BLINK_CYCLES.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

  // Strobes land in the pending buffer; active only changes at a frame wrap,
  // and a strobe in the wrap cycle itself goes straight to active.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pend_cards <= '0;
      pend_blink <= '0;
      pend_flag  <= 1'b0;
      act_cards  <= '0;
      act_blink  <= '0;
    end else if (wrap) begin
      if (cards_valid_in) begin
        act_cards <= cards_in;
        act_blink <= blink_in;
      end else if (pend_flag) begin
        act_cards <= pend_cards;
        act_blink <= pend_blink;
      end
      pend_flag <= 1'b0;
    end else if (cards_valid_in) begin
      pend_cards <= cards_in;
      pend_blink <= blink_in;
      pend_flag  <= 1'b1;
    end
  end

  // Registered pin drivers, one cycle behind digit_idx; blank slots turn the anode off.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      an_out    <= 8'hFF;
      cat_out   <= SEG_BLANK;
      frame_out <= 1'b0;
    end else begin
      frame_out <= wrap;
      if (cur_blank) begin
        an_out  <= 8'hFF;
        cat_out <= SEG_BLANK;
      end else begin
        an_out  <= ~(8'd1 << digit_idx);
        cat_out <= ~glyph;
      end
    end
  end

endmodule
